// File: rtl/mult_arb_pkg.sv
// Shared constants for the shared-multiplier arbiter: default width, channel ids
// and the arbiter history reset value.
package mult_arb_pkg;
  localparam int   WIDTH_DEF     = 8;
  localparam logic CH0           = 1'b0;
  localparam logic CH1           = 1'b1;
  // Reset history points at channel 1 so channel 0 wins the first contest.
  localparam logic LAST_GNT_RST  = CH1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the grant history
// register lives in the instantiating block.
module rr_arb2
  import mult_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  always_comb begin
    grant = CH0;
    unique case (req)
      2'b01:   grant = CH0;
      2'b10:   grant = CH1;
      2'b11:   grant = ~last_grant;
      default: grant = CH0;
    endcase
  end
endmodule

// File: rtl/mult_share_arb.sv
// Two requesters sharing one WIDTH x WIDTH multiplier behind a round-robin arbiter
// and a two-stage pipeline. Define MULT_ARB_ISO_EN to zero the multiplier inputs
// whenever stage 1 is empty.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_id,
  output logic               busy
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][WIDTH-1:0] op_a_q, op_b_q;
  logic [NUM_CH-1:0][WIDTH-1:0] in_a, in_b;
  logic [NUM_CH-1:0]            vld, acc;
  logic                         s1_valid_q, s1_id_q, last_grant_q;
  logic                         res_valid_q, res_id_q;
  logic [2*WIDTH-1:0]           res_data_q, product;
  logic [WIDTH-1:0]             mul_a, mul_b;
  logic                         grant, s2_load, s1_free;

  assign vld  = {req1_valid, req0_valid};
  assign in_a = {req1_a, req0_a};
  assign in_b = {req1_b, req0_b};

  rr_arb2 u_arb (
    .req        (vld),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign s2_load = ~res_valid_q | res_ready;
  assign s1_free = ~s1_valid_q | s2_load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rdy
    assign acc[c] = s1_free & vld[c] & (grant == c[0]);
  end

  assign req0_ready = acc[0];
  assign req1_ready = acc[1];

  // Operand registers load only on their own channel's accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc[c]) begin
          op_a_q[c] <= in_a[c];
          op_b_q[c] <= in_b[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= CH0;
      last_grant_q <= LAST_GNT_RST;
    end else if (s1_free) begin
      s1_valid_q <= |acc;
      if (|acc) begin
        s1_id_q      <= acc[1];
        last_grant_q <= acc[1];
      end
    end
  end

`ifdef MULT_ARB_ISO_EN
  assign mul_a = s1_valid_q ? op_a_q[s1_id_q] : '0;
  assign mul_b = s1_valid_q ? op_b_q[s1_id_q] : '0;
`else
  assign mul_a = op_a_q[s1_id_q];
  assign mul_b = op_b_q[s1_id_q];
`endif

  assign product = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= CH0;
    end else if (s2_load) begin
      res_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_data_q <= product;
        res_id_q   <= s1_id_q;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q | res_valid_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized + directed bench for mult_share_arb against a transaction-queue model.
module tb_mult_share_arb;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           res_valid, res_id, busy;
  logic           res_ready = 1'b1;
  logic [2*W-1:0] res_data;

  int checks = 0;
  int errors = 0;

  mult_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight transactions in order, each with edges elapsed since accept.
  typedef struct {
    logic     id;
    int       prod;
    int       age;
  } txn_t;
  txn_t   mq[$];
  logic   m_last = 1'b1;
  int     m_a0 = 0, m_b0 = 0;

  always @(negedge clk) begin
    logic e_rv, en, g, e0, e1;
    if (!rst) begin
      mq.delete();
      m_last = 1'b1;
      m_a0 = 0;
      m_b0 = 0;
    end else begin
      e_rv = (mq.size() > 0) && (mq[0].age >= 1);
      en   = (mq.size() < 2) || res_ready;
      if (req0_valid && !req1_valid)      g = 1'b0;
      else if (req1_valid && !req0_valid) g = 1'b1;
      else                                g = !m_last;
      e0 = req0_valid && en && !g;
      e1 = req1_valid && en && g;
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("res_valid", 32'(res_valid), 32'(e_rv));
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      if (e_rv) begin
        chk("res_data", 32'(res_data), 32'(mq[0].prod));
        chk("res_id", 32'(res_id), 32'(mq[0].id));
      end
      chk("ch0_opa_hold", 32'(dut.op_a_q[0]), 32'(m_a0));
      chk("ch0_opb_hold", 32'(dut.op_b_q[0]), 32'(m_b0));
`ifdef MULT_ARB_ISO_EN
      if (!dut.s1_valid_q) begin
        chk("iso_a", 32'(dut.mul_a), 32'd0);
        chk("iso_b", 32'(dut.mul_b), 32'd0);
      end
`endif
      foreach (mq[i]) mq[i].age++;
      if (e_rv && res_ready) void'(mq.pop_front());
      if (e0) begin
        mq.push_back('{1'b0, int'(req0_a) * int'(req0_b), 0});
        m_a0 = int'(req0_a);
        m_b0 = int'(req0_b);
        m_last = 1'b0;
      end
      if (e1) begin
        mq.push_back('{1'b1, int'(req1_a) * int'(req1_b), 0});
        m_last = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    rst = 1'b1;
    step();

    // Single ch0 request
    req0_valid = 1; req0_a = 3; req0_b = 5; res_ready = 1;
    #1 chk("single_ready0", 32'(req0_ready), 32'd1);
    step(); req0_valid = 0;
    step();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", 32'(res_data), 32'd15);
    chk("single_id", 32'(res_id), 32'd0);

    // Corner values
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'hFF;
    step(); req1_valid = 0;
    step();
    chk("ffxff_data", 32'(res_data), 32'hFE01);
    chk("ffxff_id", 32'(res_id), 32'd1);
    req0_valid = 1; req0_a = 0; req0_b = 8'hFF;
    step(); req0_valid = 0;
    step();
    chk("zero_data", 32'(res_data), 32'd0);
    chk("zero_id", 32'(res_id), 32'd0);
    step();

    // Backpressure with three ch1 requests
    res_ready = 0;
    req1_valid = 1; req1_a = 1; req1_b = 2;
    step(); req1_a = 3; req1_b = 4;
    step(); req1_a = 5; req1_b = 6;
    #1;
    chk("bp_third_ready", 32'(req1_ready), 32'd0);
    chk("bp_hold_data", 32'(res_data), 32'd2);
    step();
    chk("bp_hold_data2", 32'(res_data), 32'd2);
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    res_ready = 1;
    step(); req1_valid = 0;
    chk("bp_drain2", 32'(res_data), 32'd12);
    step();
    chk("bp_drain3", 32'(res_data), 32'd30);
    step();

    // Async reset with both stages full
    res_ready = 0; req0_valid = 1; req1_valid = 1;
    step(); step();
    req0_valid = 0; req1_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step(); rst = 1'b1;
    step();

    // Alternation under continuous dual requests
    res_ready = 1;
    req0_valid = 1; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_a = 3; req1_b = 3;
    #1 chk("first_contest_ch0", 32'(req0_ready), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_valid", 32'(res_valid), 32'd1);
      chk("alt_data", 32'(res_data), (i % 2 == 0) ? 32'd4 : 32'd9);
      chk("alt_id", 32'(res_id), 32'(i % 2));
    end

    // Random traffic on both channels
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      res_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // ch1 only; ch0 operand registers must stay put
    req0_valid = 0;
    for (int i = 0; i < 300; i++) begin
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_valid = $urandom_range(0, 1);
      req1_a = W'($urandom); req1_b = W'($urandom);
      res_ready = ($urandom_range(0, 99) < 60);
      step();
    end

    req1_valid = 0; res_ready = 1;
    repeat (5) step();
    chk("drained_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
